// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets,
// status bit positions and the address region decoder.
package dmem_responder_pkg;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_FF00;

    localparam logic [1:0] OFF_CYCLE  = 2'd0;
    localparam logic [1:0] OFF_LED    = 2'd1;
    localparam logic [1:0] OFF_TIMER  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int ST_TIMER     = 0;
    localparam int ST_ERR       = 1;
    localparam int STATUS_WIDTH = 2;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_MMIO = 2'd2
    } region_e;

    // RAM occupies the bottom of the word space; the MMIO window is four words.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input int unsigned addr_width,
                                              input logic [31:0] mmio_base);
        region_e r;
        if ((addr >> addr_width) == 32'd0) begin
            r = REGION_RAM;
        end else if ((addr >= mmio_base) && (addr <= (mmio_base + 32'd3))) begin
            r = REGION_MMIO;
        end else begin
            r = REGION_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_timer.sv
// Countdown timer: a load replaces the count, otherwise a nonzero count
// decrements once per edge and flags the 1->0 step with expire_pulse.
module mmio_timer (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] count,
    output logic        expire_pulse
);

    logic [31:0] count_r;
    logic [31:0] count_next_s;

    // Next count: a load wins over the decrement on the same edge.
    always_comb begin
        count_next_s = count_r;
        if (load) begin
            count_next_s = load_value;
        end else if (count_r != 32'd0) begin
            count_next_s = count_r - 32'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= 32'd0;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count        = count_r;
    assign expire_pulse = (!load) && (count_r == 32'd1);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed synchronous RAM plus a four-word
// peripheral window (cycle counter, LEDs, countdown timer, status).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE,
    parameter int          LED_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          address_dmem,
    input  logic [31:0]          data,
    input  logic                 wren,
    output logic [31:0]          q_dmem,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 timer_irq
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]             ram_r [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0]   ram_idx_s;
    region_e                 region_s;
    logic [1:0]              offset_s;

    logic                    ram_we_s;
    logic                    led_we_s;
    logic                    timer_we_s;
    logic                    status_we_s;
    logic                    err_set_s;

    logic [31:0]             cycle_r;
    logic [LED_WIDTH-1:0]    led_r;
    logic [STATUS_WIDTH-1:0] status_r;
    logic [STATUS_WIDTH-1:0] status_next_s;
    logic [31:0]             q_dmem_r;
    logic [31:0]             rd_data_s;
    logic [31:0]             timer_count_s;
    logic                    timer_expire_s;

    assign ram_idx_s = address_dmem[ADDR_WIDTH-1:0];
    assign region_s  = decode_region(address_dmem, ADDR_WIDTH, MMIO_BASE);
    // The window is contiguous, so the low two bits of the difference select the register.
    assign offset_s  = address_dmem[1:0] - MMIO_BASE[1:0];

    // Write strobes; CYCLE writes are silently ignored, unmapped writes flag an error.
    always_comb begin
        ram_we_s    = 1'b0;
        led_we_s    = 1'b0;
        timer_we_s  = 1'b0;
        status_we_s = 1'b0;
        err_set_s   = 1'b0;
        if (wren) begin
            case (region_s)
                REGION_RAM:  ram_we_s = 1'b1;
                REGION_MMIO: begin
                    case (offset_s)
                        OFF_LED:    led_we_s    = 1'b1;
                        OFF_TIMER:  timer_we_s  = 1'b1;
                        OFF_STATUS: status_we_s = 1'b1;
                        default:    led_we_s    = 1'b0;
                    endcase
                end
                default:     err_set_s = 1'b1;
            endcase
        end else begin
            ram_we_s = 1'b0;
        end
    end

    // Read source selection, sampled into q_dmem at the edge.
    always_comb begin
        rd_data_s = 32'd0;
        case (region_s)
            REGION_RAM:  rd_data_s = ram_r[ram_idx_s];
            REGION_MMIO: begin
                case (offset_s)
                    OFF_CYCLE:  rd_data_s = cycle_r;
                    OFF_LED:    rd_data_s = {{(32-LED_WIDTH){1'b0}}, led_r};
                    OFF_TIMER:  rd_data_s = timer_count_s;
                    OFF_STATUS: rd_data_s = {{(32-STATUS_WIDTH){1'b0}}, status_r};
                    default:    rd_data_s = 32'd0;
                endcase
            end
            default:     rd_data_s = 32'd0;
        endcase
    end

    // Status update: write-1-to-clear, with hardware set events taking priority.
    always_comb begin
        status_next_s = status_r;
        if (status_we_s) begin
            status_next_s = status_r & ~data[STATUS_WIDTH-1:0];
        end else begin
            status_next_s = status_r;
        end
        status_next_s[ST_TIMER] = status_next_s[ST_TIMER] | timer_expire_s;
        status_next_s[ST_ERR]   = status_next_s[ST_ERR] | err_set_s;
    end

    // Block RAM storage; no reset so it maps onto a RAM primitive.
    always_ff @(posedge clock) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= data;
        end
    end

    // Peripheral registers and the registered read port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_r  <= 32'd0;
            led_r    <= {LED_WIDTH{1'b0}};
            status_r <= {STATUS_WIDTH{1'b0}};
            q_dmem_r <= 32'd0;
        end else begin
            cycle_r  <= cycle_r + 32'd1;
            status_r <= status_next_s;
            q_dmem_r <= rd_data_s;
            if (led_we_s) begin
                led_r <= data[LED_WIDTH-1:0];
            end
        end
    end

    mmio_timer u_timer (
        .clock        (clock),
        .reset        (reset),
        .load         (timer_we_s),
        .load_value   (data),
        .count        (timer_count_s),
        .expire_pulse (timer_expire_s)
    );

    assign q_dmem    = q_dmem_r;
    assign leds      = led_r;
    assign timer_irq = status_r[ST_TIMER];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: RAM timing, cycle counter,
// LEDs, countdown timer, status W1C, unmapped accesses and asynchronous reset.
module tb_dmem_responder;

    localparam logic [31:0] A_CYC = 32'hFFFF_FF00;
    localparam logic [31:0] A_LED = 32'hFFFF_FF01;
    localparam logic [31:0] A_TMR = 32'hFFFF_FF02;
    localparam logic [31:0] A_ST  = 32'hFFFF_FF03;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [15:0] leds;
    logic        timer_irq;

    int errors = 0;
    int checks = 0;

    dmem_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .leds         (leds),
        .timer_irq    (timer_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one access and let exactly one rising edge consume it.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
        address_dmem = a;
        data         = d;
        wren         = w;
        @(negedge clock);
    endtask

    task automatic test_reset;
        @(negedge clock);
        @(negedge clock);
        checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL reset_q got=%h exp=%h", q_dmem, 32'd0); end
        checks++; if (leds !== 16'd0) begin errors++; $display("FAIL reset_leds got=%h exp=%h", leds, 16'd0); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=%b", timer_irq, 1'b0); end
        address_dmem = A_CYC;
        reset = 1'b1;
    endtask

    task automatic test_cycle;
        for (int i = 0; i < 10; i++) cyc(A_CYC, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd9) begin errors++; $display("FAIL cycle_read got=%0d exp=%0d", q_dmem, 9); end
        cyc(A_CYC, 32'h1234, 1'b1);
        cyc(A_CYC, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd11) begin errors++; $display("FAIL cycle_write_ignored got=%0d exp=%0d", q_dmem, 11); end
        cyc(A_ST, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL cycle_write_no_err got=%h exp=%h", q_dmem, 32'd0); end
    endtask

    task automatic test_ram;
        cyc(32'd5, 32'hDEAD_BEEF, 1'b1);
        cyc(32'd5, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_read got=%h exp=%h", q_dmem, 32'hDEAD_BEEF); end
        cyc(32'd5, 32'd1, 1'b1);
        checks++; if (q_dmem !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_read_first got=%h exp=%h", q_dmem, 32'hDEAD_BEEF); end
        cyc(32'd5, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd1) begin errors++; $display("FAIL ram_after_write got=%h exp=%h", q_dmem, 32'd1); end
    endtask

    task automatic test_timer;
        cyc(A_TMR, 32'd3, 1'b1);
        cyc(A_TMR, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd3) begin errors++; $display("FAIL timer_load got=%0d exp=%0d", q_dmem, 3); end
        cyc(A_TMR, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd2) begin errors++; $display("FAIL timer_cnt2 got=%0d exp=%0d", q_dmem, 2); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_irq_early got=%b exp=%b", timer_irq, 1'b0); end
        cyc(A_TMR, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd1) begin errors++; $display("FAIL timer_cnt1 got=%0d exp=%0d", q_dmem, 1); end
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL timer_irq_set got=%b exp=%b", timer_irq, 1'b1); end
        cyc(A_TMR, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL timer_cnt0 got=%0d exp=%0d", q_dmem, 0); end
        cyc(A_ST, 32'd1, 1'b1);
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_irq_clear got=%b exp=%b", timer_irq, 1'b0); end
        // Writing 0 on the edge that would have expired must not raise bit0.
        cyc(A_TMR, 32'd2, 1'b1);
        cyc(A_TMR, 32'd0, 1'b0);
        cyc(A_TMR, 32'd0, 1'b1);
        cyc(A_ST, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL timer_stop_status got=%h exp=%h", q_dmem, 32'd0); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_stop_irq got=%b exp=%b", timer_irq, 1'b0); end
    endtask

    task automatic test_simultaneous;
        cyc(A_TMR, 32'd2, 1'b1);
        cyc(A_TMR, 32'd0, 1'b0);
        cyc(A_ST, 32'd1, 1'b1);
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL set_beats_clear got=%b exp=%b", timer_irq, 1'b1); end
        cyc(A_ST, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd1) begin errors++; $display("FAIL status_bit0 got=%h exp=%h", q_dmem, 32'd1); end
        cyc(A_ST, 32'd1, 1'b1);
        cyc(A_TMR, 32'd10, 1'b1);
        cyc(A_TMR, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd10) begin errors++; $display("FAIL reload_first got=%0d exp=%0d", q_dmem, 10); end
        cyc(A_TMR, 32'd5, 1'b1);
        checks++; if (q_dmem !== 32'd9) begin errors++; $display("FAIL reload_prewrite got=%0d exp=%0d", q_dmem, 9); end
        cyc(A_TMR, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd5) begin errors++; $display("FAIL reload_wins got=%0d exp=%0d", q_dmem, 5); end
        cyc(A_TMR, 32'd0, 1'b1);
    endtask

    task automatic test_unmapped;
        cyc(32'd0, 32'h1111_1111, 1'b1);
        cyc(32'h0001_0000, 32'hCAFE_F00D, 1'b1);
        checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL unmapped_read got=%h exp=%h", q_dmem, 32'd0); end
        cyc(A_ST, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd2) begin errors++; $display("FAIL unmapped_err got=%h exp=%h", q_dmem, 32'd2); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL unmapped_irq got=%b exp=%b", timer_irq, 1'b0); end
        cyc(32'd0, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'h1111_1111) begin errors++; $display("FAIL unmapped_ram_intact got=%h exp=%h", q_dmem, 32'h1111_1111); end
        cyc(A_ST, 32'd2, 1'b1);
        cyc(A_ST, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL err_w1c got=%h exp=%h", q_dmem, 32'd0); end
        // RAM top word versus the first word past RAM.
        cyc(32'h0000_0FFF, 32'h77, 1'b1);
        cyc(32'h0000_1000, 32'h88, 1'b1);
        cyc(32'h0000_0FFF, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'h77) begin errors++; $display("FAIL ram_top got=%h exp=%h", q_dmem, 32'h77); end
        cyc(A_ST, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd2) begin errors++; $display("FAIL ram_past_end_err got=%h exp=%h", q_dmem, 32'd2); end
        cyc(32'd0, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'h1111_1111) begin errors++; $display("FAIL ram_no_alias got=%h exp=%h", q_dmem, 32'h1111_1111); end
        // First word past the MMIO window.
        cyc(A_ST, 32'd2, 1'b1);
        cyc(32'hFFFF_FF04, 32'h99, 1'b1);
        cyc(A_ST, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd2) begin errors++; $display("FAIL mmio_past_end_err got=%h exp=%h", q_dmem, 32'd2); end
        cyc(A_ST, 32'd2, 1'b1);
    endtask

    task automatic test_led_reset;
        cyc(A_LED, 32'h0000_A5A5, 1'b1);
        checks++; if (leds !== 16'hA5A5) begin errors++; $display("FAIL led_write got=%h exp=%h", leds, 16'hA5A5); end
        cyc(A_LED, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'h0000_A5A5) begin errors++; $display("FAIL led_read got=%h exp=%h", q_dmem, 32'h0000_A5A5); end
        cyc(A_LED, 32'hFFFF_1234, 1'b1);
        cyc(A_LED, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'h0000_1234) begin errors++; $display("FAIL led_zero_ext got=%h exp=%h", q_dmem, 32'h0000_1234); end
        cyc(A_TMR, 32'd4, 1'b1);
        cyc(A_TMR, 32'd0, 1'b0);
        // Asynchronous reset between edges, with the timer mid-countdown.
        address_dmem = A_CYC;
        wren = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (leds !== 16'd0) begin errors++; $display("FAIL async_leds got=%h exp=%h", leds, 16'd0); end
        checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL async_q got=%h exp=%h", q_dmem, 32'd0); end
        #1;
        reset = 1'b1;
        @(negedge clock);
        cyc(A_CYC, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd1) begin errors++; $display("FAIL cycle_after_reset got=%0d exp=%0d", q_dmem, 1); end
        for (int i = 0; i < 6; i++) cyc(A_ST, 32'd0, 1'b0);
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_stops_timer got=%b exp=%b", timer_irq, 1'b0); end
        cyc(A_TMR, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd0) begin errors++; $display("FAIL timer_cleared got=%0d exp=%0d", q_dmem, 0); end
        cyc(32'd5, 32'd0, 1'b0);
        checks++; if (q_dmem !== 32'd1) begin errors++; $display("FAIL ram_kept got=%h exp=%h", q_dmem, 32'd1); end
    endtask

    initial begin
        reset        = 1'b0;
        address_dmem = 32'd0;
        data         = 32'd0;
        wren         = 1'b0;
        test_reset();
        test_cycle();
        test_ram();
        test_timer();
        test_simultaneous();
        test_unmapped();
        test_led_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the processor's dmem port: it receives address_dmem, data and wren, and returns q_dmem.
- Contains a word-addressed synchronous RAM plus a small memory-mapped peripheral window: cycle counter, LED register, countdown timer and status register.
- Instantiated in the Wrapper in place of the bare dmem. The processor sees the same one-cycle read timing as before.

Parameters:
- ADDR_WIDTH, 12, RAM index width; RAM depth = 2**ADDR_WIDTH words of 32 bits.
- MMIO_BASE, 32'hFFFF_FF00, word address of the first peripheral register. The window is 4 words: MMIO_BASE+0..+3.
- LED_WIDTH, 16, width of the LED output register.

Ports:
- clock  input  1  master clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; reset=0 clears all registers immediately.
- address_dmem  input  32  word address from processor.
- data  input  32  write data from processor.
- wren  input  1  write enable; qualifies data at address_dmem this cycle.
- q_dmem  output  32  read data, registered.
- leds  output  LED_WIDTH  LED register contents.
- timer_irq  output  1  level, equals status bit0 (timer expired).

Behaviour:
- Address decode, combinational on address_dmem:
  - RAM hit: address_dmem < 2**ADDR_WIDTH.
  - MMIO hit: MMIO_BASE <= address_dmem <= MMIO_BASE+3.
  - Everything else is unmapped.
- Read, 1-cycle latency:
  - At each rising edge, q_dmem <= the selected source, sampled at that edge.
  - RAM: array[address_dmem[ADDR_WIDTH-1:0]].
  - Unmapped: 32'h0.
- Read-first on same-cycle write: if wren=1 at an edge, q_dmem returns the pre-write value of that location.
- Write:
  - When wren=1 at a rising edge, RAM or the writable MMIO register is updated.
  - Writes to unmapped addresses are dropped and set status bit1 (sticky).
- MMIO map (offset from MMIO_BASE):
  - +0 CYCLE, RO: 32-bit free-running counter, +1 every edge, wraps 32'hFFFF_FFFF -> 0. Writes are ignored and are not errors.
  - +1 LED, RW: low LED_WIDTH bits stored; read returns zero-extended value.
  - +2 TIMER, RW: a write loads the count. While the count is nonzero it decrements by 1 per edge. On the 1->0 transition, status bit0 is set.
    - Writing 0 stops the timer and does not set bit0.
    - Read returns the current count.
  - +3 STATUS: bit0 = timer expired, bit1 = unmapped-access error, bits[31:2] read 0.
    - Write-1-to-clear per bit; writing 0 leaves the bit unchanged.
- Simultaneous events:
  - TIMER write on the same edge as a decrement: the loaded value wins; no decrement that edge.
  - STATUS W1C of bit0 on the same edge the timer reaches 0: set wins, bit0 stays 1.
  - Read of CYCLE returns the pre-increment value of that edge.
- Reset (reset=0, asynchronous):
  - q_dmem=0, leds=0, timer_irq=0, CYCLE=0, TIMER=0, STATUS=0.
  - RAM contents are not cleared (block RAM; no reset port).
  - Reset mid-countdown stops the timer with no irq.
  - After reset releases, the first edge increments CYCLE to 1.
- No stall or ready signalling; every access completes in one cycle.

Decomposition:
- Shared package holds:
  - MMIO offsets: OFF_CYCLE=0, OFF_LED=1, OFF_TIMER=2, OFF_STATUS=3.
  - STATUS bit indices: ST_TIMER=0, ST_ERR=1.
  - Default MMIO_BASE.
- One sub-module, mmio_timer: TIMER count register, decrement logic and expired-set pulse. It takes a load strobe and value and exposes count and expire_pulse.
- RAM is inferred inline in dmem_responder.

Test Plan:
- Write 32'hDEADBEEF to addr 5, then read addr 5 on the next cycle -> q_dmem=32'hDEADBEEF one edge after the read address is presented. A same-edge write-and-read of addr 5 with 32'h1 returns 32'hDEADBEEF.
- Release reset, then read CYCLE after 10 edges -> returns 9 (pre-increment). Write 32'h1234 to CYCLE -> value unaffected and STATUS bit1 stays 0.
- Write 32'h0000_A5A5 to LED -> leds=16'hA5A5 after that edge. Read LED -> 32'h0000A5A5. Assert reset=0 mid-cycle -> leds=0 immediately, without waiting for an edge.
- Write TIMER=3 -> counts 2,1,0 on successive edges. timer_irq rises on the edge where the count hits 0. Write STATUS=1 -> timer_irq=0.
- Timer reaches 0 on the same edge as a STATUS=1 write -> timer_irq stays 1. Reload TIMER=5 while counting -> next read is 5.
- Write to unmapped addr 32'h0001_0000 -> RAM unchanged, STATUS reads 32'h2. Read same addr -> q_dmem=0. Write STATUS=2 -> STATUS reads 0.
